// File: rtl/fetch_decode_ctrl.sv
// IF/ID pipeline register with load/branch-operand stall, ID-stage branch resolution and squash of the fall-through slot.
// Build option DELAY_SLOT_EN: keep the instruction fetched after a taken branch (DLX delay slot) instead of squashing it.
module fetch_decode_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrIn,
    input  logic [31:0] PCIn,
    input  logic [31:0] RegA,
    input  logic        ExWrEn,
    input  logic [4:0]  ExRd,
    input  logic        ExIsLoad,
    output logic        Branch,
    output logic [31:0] BranchPC,
    output logic        stall,
    output logic [31:0] InstrOut,
    output logic [31:0] PCOut,
    output logic        Valid,
    output logic [15:0] BranchCount,
    output logic [15:0] StallCount
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SQUASH = 2'd2
    } state_e;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_JR   = 6'h12;
    localparam logic [5:0] OP_JALR = 6'h13;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [15:0] br_cnt_q, br_cnt_d;
    logic [15:0] st_cnt_q, st_cnt_d;

    logic [5:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic        taken, rs1_early;
    logic        load_hazard, ctrl_hazard;
    logic [31:0] target;

    assign opcode = instr_q[31:26];
    assign rs1    = instr_q[25:21];
    assign rs2    = instr_q[20:16];

    // NOTE: every always_comb output is given a default first; any path that skipped one would infer a latch.
    always_comb begin
        taken     = 1'b0;
        rs1_early = 1'b0;
        target    = 32'h0;
        case (opcode)
            OP_BEQZ: begin
                taken     = (RegA == 32'h0);
                rs1_early = 1'b1;
                target    = pc_q + 32'd4 + {{16{instr_q[15]}}, instr_q[15:0]};
            end
            OP_BNEZ: begin
                taken     = (RegA != 32'h0);
                rs1_early = 1'b1;
                target    = pc_q + 32'd4 + {{16{instr_q[15]}}, instr_q[15:0]};
            end
            OP_J, OP_JAL: begin
                taken  = 1'b1;
                target = pc_q + 32'd4 + {{6{instr_q[25]}}, instr_q[25:0]};
            end
            OP_JR, OP_JALR: begin
                taken     = 1'b1;
                rs1_early = 1'b1;
                target    = RegA;
            end
            default: ;
        endcase
    end

    // Branches read rs1 in ID, so any EX writer of rs1 must finish first; loads block both sources.
    assign load_hazard = valid_q && ExIsLoad && (ExRd != 5'd0) && ((ExRd == rs1) || (ExRd == rs2));
    assign ctrl_hazard = valid_q && rs1_early && ExWrEn && (ExRd != 5'd0) && (ExRd == rs1);

    assign stall       = load_hazard || ctrl_hazard;
    assign Branch      = taken && valid_q && !stall;
    assign BranchPC    = Branch ? target : 32'h0;
    assign InstrOut    = instr_q;
    assign PCOut       = pc_q;
    assign Valid       = valid_q;
    assign BranchCount = br_cnt_q;
    assign StallCount  = st_cnt_q;

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        br_cnt_d = br_cnt_q;
        st_cnt_d = st_cnt_q;

        case (state_q)
            RUN, STALL: begin
`ifdef DELAY_SLOT_EN
                state_d = stall ? STALL : RUN;
`else
                if (Branch) begin
                    state_d = SQUASH;
                end else begin
                    state_d = stall ? STALL : RUN;
                end
`endif
            end
            SQUASH:  state_d = RUN;
            default: state_d = RUN;
        endcase

        // The edge that enters SQUASH replaces the fall-through fetch with a bubble.
        if (state_d == SQUASH) begin
            instr_d = 32'h0;
            pc_d    = PCIn;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = InstrIn;
            pc_d    = PCIn;
            valid_d = 1'b1;
        end

        if (Branch && (br_cnt_q != 16'hFFFF)) begin
            br_cnt_d = br_cnt_q + 16'd1;
        end
        if (stall && (st_cnt_q != 16'hFFFF)) begin
            st_cnt_d = st_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            instr_q  <= 32'h0;
            pc_q     <= 32'h0;
            valid_q  <= 1'b0;
            br_cnt_q <= 16'h0;
            st_cnt_q <= 16'h0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            br_cnt_q <= br_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Scoreboard bench for fetch_decode_ctrl: expectations are queued as stimulus is applied and popped when outputs are sampled.
// Flags are compared packed as {Valid, Branch, stall}; counters as {BranchCount, StallCount}.
module tb_fetch_decode_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrIn, PCIn, RegA;
    logic        ExWrEn, ExIsLoad;
    logic [4:0]  ExRd;
    logic        Branch, stall, Valid;
    logic [31:0] BranchPC, InstrOut, PCOut;
    logic [15:0] BranchCount, StallCount;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    int          exp_bc   = 0;
    int          exp_sc   = 0;

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    // Instruction words: opcode | rs1 | rs2 | immediate
    logic [31:0] add_r3, w1, beqz_r1_p8, bnez_r2_m8, jr_r5, j_m4, jal_p8;

    fetch_decode_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .InstrIn    (InstrIn),
        .PCIn       (PCIn),
        .RegA       (RegA),
        .ExWrEn     (ExWrEn),
        .ExRd       (ExRd),
        .ExIsLoad   (ExIsLoad),
        .Branch     (Branch),
        .BranchPC   (BranchPC),
        .stall      (stall),
        .InstrOut   (InstrOut),
        .PCOut      (PCOut),
        .Valid      (Valid),
        .BranchCount(BranchCount),
        .StallCount (StallCount)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rega,
                         input logic wr, input logic [4:0] rd, input logic ld);
        @(negedge clk);
        InstrIn = instr; PCIn = pc; RegA = rega; ExWrEn = wr; ExRd = rd; ExIsLoad = ld;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        reset = 1'b1;
        InstrIn = 32'hDEAD_BEEF; PCIn = 32'h0000_1000; RegA = 32'h0;
        ExWrEn = 1'b0; ExRd = 5'd0; ExIsLoad = 1'b0;
        #1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", InstrOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if (PCOut !== e) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", PCOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        e = sb_q.pop_front(); n_assert++;
        if (BranchPC !== e) begin n_fail++; $display("FAIL reset_bpc: got %h expected %h", BranchPC, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({BranchCount, StallCount} !== e) begin n_fail++; $display("FAIL reset_counts: got %h expected %h", {BranchCount, StallCount}, e); end
        reset = 1'b0;
    endtask

    task automatic test_capture;
        logic [31:0] e;
        drive(add_r3, 32'h40, 32'h0, 1'b0, 5'd0, 1'b0);
        sb_q.push_back(add_r3); sb_q.push_back(32'h40); sb_q.push_back(32'b100);
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL capture_instr: got %h expected %h", InstrOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if (PCOut !== e) begin n_fail++; $display("FAIL capture_pc: got %h expected %h", PCOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL capture_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
    endtask

    task automatic test_cond_branch;
        logic [31:0] e;
        drive(beqz_r1_p8, 32'h100, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        // BEQZ with RegA=7: not taken, BranchPC forced to zero
        drive(w1, 32'h104, 32'h7, 1'b0, 5'd0, 1'b0);
        sb_q.push_back(32'b100); sb_q.push_back(32'h0);
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL beqz_nt_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        e = sb_q.pop_front(); n_assert++;
        if (BranchPC !== e) begin n_fail++; $display("FAIL beqz_nt_bpc: got %h expected %h", BranchPC, e); end
        RegA = 32'h0;
        #1;
        sb_q.push_back(32'b110); sb_q.push_back(32'h10C);
        exp_bc++;
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL beqz_t_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        e = sb_q.pop_front(); n_assert++;
        if (BranchPC !== e) begin n_fail++; $display("FAIL beqz_t_bpc: got %h expected %h", BranchPC, e); end
        sb_q.push_back(DS ? w1 : 32'h0); sb_q.push_back(32'h104);
        sb_q.push_back({29'h0, DS, 2'b00}); sb_q.push_back(32'(exp_bc));
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL slot_instr: got %h expected %h", InstrOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if (PCOut !== e) begin n_fail++; $display("FAIL slot_pc: got %h expected %h", PCOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL slot_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        e = sb_q.pop_front(); n_assert++;
        if ({16'h0, BranchCount} !== e) begin n_fail++; $display("FAIL beqz_count: got %0d expected %0d", BranchCount, e); end
        // Bubble cycle: an EX load to r3 must not stall an empty or unrelated ID slot
        drive(add_r3, 32'h10C, 32'h0, 1'b0, 5'd3, 1'b1);
        sb_q.push_back({29'h0, DS, 2'b00});
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL bubble_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        sb_q.push_back(add_r3); sb_q.push_back(32'h10C);
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL target_instr: got %h expected %h", InstrOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if (PCOut !== e) begin n_fail++; $display("FAIL target_pc: got %h expected %h", PCOut, e); end
        // BNEZ backward: RegA=0 not taken, RegA=0x80000000 taken to 0x200+4-8
        drive(bnez_r2_m8, 32'h200, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(w1, 32'h204, 32'h0, 1'b0, 5'd0, 1'b0);
        sb_q.push_back(32'b100);
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL bnez_nt_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        RegA = 32'h8000_0000;
        #1;
        sb_q.push_back(32'h1FC);
        exp_bc++;
        e = sb_q.pop_front(); n_assert++;
        if (BranchPC !== e) begin n_fail++; $display("FAIL bnez_t_bpc: got %h expected %h", BranchPC, e); end
        tick;
        drive(add_r3, 32'h1FC, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
    endtask

    task automatic test_load_stall;
        logic [31:0] e;
        drive(add_r3, 32'h300, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        // Non-load EX writer of r3 does not stall a non-branch
        drive(w1, 32'h304, 32'h0, 1'b1, 5'd3, 1'b0);
        sb_q.push_back(32'b100);
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL alu_nostall: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        ExWrEn = 1'b0; ExIsLoad = 1'b1; ExRd = 5'd0;
        #1;
        sb_q.push_back(32'b100);
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL load_r0_nostall: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        ExRd = 5'd3;
        #1;
        sb_q.push_back(32'b101);
        exp_sc++;
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL load_rs1_stall: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        sb_q.push_back(add_r3); sb_q.push_back(32'h300); sb_q.push_back(32'(exp_sc));
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL stall_hold_instr: got %h expected %h", InstrOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if (PCOut !== e) begin n_fail++; $display("FAIL stall_hold_pc: got %h expected %h", PCOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({16'h0, StallCount} !== e) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", StallCount, e); end
        drive(w1, 32'h304, 32'h0, 1'b0, 5'd4, 1'b1);
        sb_q.push_back(32'b101);
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL load_rs2_stall: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        ExIsLoad = 1'b0;
        #1;
        sb_q.push_back(w1); sb_q.push_back(32'(exp_sc));
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL stall_release_instr: got %h expected %h", InstrOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({16'h0, StallCount} !== e) begin n_fail++; $display("FAIL stall_count_after: got %0d expected %0d", StallCount, e); end
    endtask

    task automatic test_jr_hazard;
        logic [31:0] e;
        drive(jr_r5, 32'h400, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(w1, 32'h404, 32'h2000, 1'b1, 5'd5, 1'b0);
        sb_q.push_back(32'b101); sb_q.push_back(32'h0);
        exp_sc++;
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL jr_stall_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        e = sb_q.pop_front(); n_assert++;
        if (BranchPC !== e) begin n_fail++; $display("FAIL jr_stall_bpc: got %h expected %h", BranchPC, e); end
        sb_q.push_back(jr_r5);
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL jr_hold_instr: got %h expected %h", InstrOut, e); end
        drive(w1, 32'h404, 32'h2000, 1'b0, 5'd0, 1'b0);
        sb_q.push_back(32'b110); sb_q.push_back(32'h2000);
        exp_bc++;
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL jr_taken_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        e = sb_q.pop_front(); n_assert++;
        if (BranchPC !== e) begin n_fail++; $display("FAIL jr_taken_bpc: got %h expected %h", BranchPC, e); end
        sb_q.push_back({exp_bc[15:0], exp_sc[15:0]});
        tick;
        e = sb_q.pop_front(); n_assert++;
        if ({BranchCount, StallCount} !== e) begin n_fail++; $display("FAIL jr_counts: got %h expected %h", {BranchCount, StallCount}, e); end
        drive(add_r3, 32'h2000, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
    endtask

    task automatic test_jump_wrap;
        logic [31:0] e;
        drive(j_m4, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(w1, 32'h4, 32'h0, 1'b0, 5'd0, 1'b0);
        sb_q.push_back(32'b110); sb_q.push_back(32'h0);
        exp_bc++;
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL j_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        e = sb_q.pop_front(); n_assert++;
        if (BranchPC !== e) begin n_fail++; $display("FAIL j_bpc: got %h expected %h", BranchPC, e); end
        sb_q.push_back(DS ? w1 : 32'h0); sb_q.push_back({29'h0, DS, 2'b00}); sb_q.push_back(32'h4);
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL j_slot_instr: got %h expected %h", InstrOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL j_slot_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        e = sb_q.pop_front(); n_assert++;
        if (PCOut !== e) begin n_fail++; $display("FAIL j_slot_pc: got %h expected %h", PCOut, e); end
        // JAL from the top of the address space wraps past zero
        drive(jal_p8, 32'hFFFF_FFF8, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(w1, 32'hFFFF_FFFC, 32'h0, 1'b0, 5'd0, 1'b0);
        sb_q.push_back(32'h4);
        exp_bc++;
        e = sb_q.pop_front(); n_assert++;
        if (BranchPC !== e) begin n_fail++; $display("FAIL jal_wrap_bpc: got %h expected %h", BranchPC, e); end
        sb_q.push_back(32'(exp_bc));
        tick;
        e = sb_q.pop_front(); n_assert++;
        if ({16'h0, BranchCount} !== e) begin n_fail++; $display("FAIL jal_count: got %0d expected %0d", BranchCount, e); end
        drive(add_r3, 32'h4, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] e;
        @(negedge clk);
        reset = 1'b1; #1; reset = 1'b0;
        exp_bc = 0; exp_sc = 0;
        drive(add_r3, 32'h500, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(w1, 32'h504, 32'h0, 1'b0, 5'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick;
        end
        sb_q.push_back(32'd5); sb_q.push_back(32'b101);
        e = sb_q.pop_front(); n_assert++;
        if ({16'h0, StallCount} !== e) begin n_fail++; $display("FAIL stall5_count: got %0d expected %0d", StallCount, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL stall5_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        #2;
        reset = 1'b1;
        #1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        e = sb_q.pop_front(); n_assert++;
        if ({InstrOut, PCOut} !== {e, 32'h0}) begin n_fail++; $display("FAIL rst_stall_regs: got %h/%h expected 0/0", InstrOut, PCOut); end
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL rst_stall_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        e = sb_q.pop_front(); n_assert++;
        if (BranchPC !== e) begin n_fail++; $display("FAIL rst_stall_bpc: got %h expected %h", BranchPC, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({BranchCount, StallCount} !== e) begin n_fail++; $display("FAIL rst_stall_counts: got %h expected %h", {BranchCount, StallCount}, e); end
        #1;
        reset = 1'b0;
        sb_q.push_back(w1); sb_q.push_back(32'h504); sb_q.push_back(32'b100);
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL rst_stall_capture_instr: got %h expected %h", InstrOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if (PCOut !== e) begin n_fail++; $display("FAIL rst_stall_capture_pc: got %h expected %h", PCOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL rst_stall_capture_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        // Reset while the fall-through slot is being squashed
        drive(j_m4, 32'h600, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(w1, 32'h604, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        #2;
        reset = 1'b1;
        #1;
        sb_q.push_back(32'h0);
        e = sb_q.pop_front(); n_assert++;
        if ({BranchCount, 13'h0, Valid, Branch, stall} !== e) begin n_fail++; $display("FAIL rst_squash_state: got %h expected %h", {BranchCount, 13'h0, Valid, Branch, stall}, e); end
        #1;
        reset = 1'b0;
        drive(add_r3, 32'h700, 32'h0, 1'b0, 5'd0, 1'b0);
        sb_q.push_back(add_r3); sb_q.push_back(32'h700); sb_q.push_back(32'b100);
        tick;
        e = sb_q.pop_front(); n_assert++;
        if (InstrOut !== e) begin n_fail++; $display("FAIL rst_squash_capture_instr: got %h expected %h", InstrOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if (PCOut !== e) begin n_fail++; $display("FAIL rst_squash_capture_pc: got %h expected %h", PCOut, e); end
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL rst_squash_capture_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
    endtask

    task automatic test_saturation;
        logic [31:0] e;
        @(negedge clk);
        force dut.br_cnt_q = 16'hFFFE;
        #1;
        release dut.br_cnt_q;
        drive(beqz_r1_p8, 32'h100, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(w1, 32'h104, 32'h0, 1'b0, 5'd0, 1'b0);
        sb_q.push_back(32'hFFFF);
        tick;
        e = sb_q.pop_front(); n_assert++;
        if ({16'h0, BranchCount} !== e) begin n_fail++; $display("FAIL sat_reach: got %h expected %h", BranchCount, e); end
        drive(beqz_r1_p8, 32'h100, 32'h0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(w1, 32'h104, 32'h0, 1'b0, 5'd0, 1'b0);
        sb_q.push_back(32'b110); sb_q.push_back(32'hFFFF);
        e = sb_q.pop_front(); n_assert++;
        if ({Valid, Branch, stall} !== e[2:0]) begin n_fail++; $display("FAIL sat_taken_flags: got %b expected %b", {Valid, Branch, stall}, e[2:0]); end
        tick;
        e = sb_q.pop_front(); n_assert++;
        if ({16'h0, BranchCount} !== e) begin n_fail++; $display("FAIL sat_hold: got %h expected %h", BranchCount, e); end
    endtask

    initial begin
        add_r3     = {6'h00, 5'd3, 5'd4, 5'd5, 11'h020};
        w1         = {6'h00, 5'd7, 5'd8, 5'd8, 11'h020};
        beqz_r1_p8 = {6'h04, 5'd1, 5'd0, 16'h0008};
        bnez_r2_m8 = {6'h05, 5'd2, 5'd0, 16'hFFF8};
        jr_r5      = {6'h12, 5'd5, 21'h0};
        j_m4       = {6'h02, 26'h3FF_FFFC};
        jal_p8     = {6'h03, 26'h000_0008};

        test_reset;
        test_capture;
        test_cond_branch;
        test_load_stall;
        test_jr_hazard;
        test_jump_wrap;
        test_reset_mid_op;
        test_saturation;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
